// File: rtl/ysyx_20020207_ifq.sv
// ysyx_20020207_ifq -- instruction fetch queue between the fetch and decode stages.
//
// Circular FIFO of {pc, inst}. The read and write pointers carry one extra wrap
// bit, so full and empty can be told apart without a separate counter.
//
// Ports:
//   clock      sole clock; all state updates on the rising edge
//   reset      asynchronous, active-low reset (clears pointers and storage)
//   in_valid   fetch stage offers an instruction
//   in_ready   queue accepts an entry this cycle (!full && !flush)
//   in_pc      PC of the offered instruction
//   in_inst    offered instruction word
//   out_valid  head entry valid to the decode stage
//   out_ready  decode stage consumes the head
//   out_pc     head PC
//   out_inst   head instruction
//   flush      jump redirect; discards all contents, highest priority
//   count      current occupancy, 0..DEPTH
//
// Optional feature macro: CONFIG_IFQ_BYPASS_EN
//   Defined   : while the queue is empty, an offered instruction can pass
//               straight to the output in the same cycle.
//   Undefined : there is no combinational path from in_* to out_*.
module ysyx_20020207_ifq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_bypass;
  logic          w_enq;
  logic          w_deq;
  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];

  // Same slot with opposite wrap bits means the writer is a full lap ahead.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  assign w_empty = (r_wptr == r_rptr);

`ifdef CONFIG_IFQ_BYPASS_EN
  assign w_bypass = w_empty && !flush && in_valid && out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = !w_full && !flush;
  assign out_valid = (!w_empty && !flush) || w_bypass;
  assign out_pc    = w_bypass ? in_pc   : r_pc_mem[w_ridx];
  assign out_inst  = w_bypass ? in_inst : r_inst_mem[w_ridx];

  // flush already forces in_ready/out_valid low, so it suppresses both handshakes.
  assign w_enq = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;

  // A bypassed instruction is both enqueued and dequeued in the same cycle;
  // the two cancel, so neither storage nor pointers move.
  assign w_wr  = w_enq && !w_bypass;
  assign w_rd  = w_deq && !w_bypass;

  assign count = r_wptr - r_rptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left untouched; only the pointers return to the origin.
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_pc_mem[w_widx]   <= in_pc;
        r_inst_mem[w_widx] <= in_inst;
        r_wptr             <= r_wptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_ifq.sv
module tb_ysyx_20020207_ifq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  ysyx_20020207_ifq #(.DEPTH(4)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    #2;
    checks++; if (count !== 3'd0)      begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0)    begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    checks++; if (out_inst !== 32'h0)  begin errors++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0000 + 32'(4 * i); in_inst = 32'h1000_0000 + 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = 32'h1000_0004;
    #1;
    checks++; if (count !== 3'd4)           begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0)        begin errors++; $display("FAIL fill_full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL fill_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL fill_out_pc: got %h expected 80000000", out_pc); end
    checks++; if (out_inst !== 32'h1000_0000) begin errors++; $display("FAIL fill_out_inst: got %h expected 10000000", out_inst); end
    tick();
    checks++; if (count !== 3'd4)           begin errors++; $display("FAIL fill_held_count: got %0d expected 4", count); end
    checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL fill_held_out_pc: got %h expected 80000000", out_pc); end
  endtask

  task automatic test_full_deq;
    // Queue full; offer held at pc 0x80000010 while decode consumes.
    in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = 32'h1000_0004; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL fulldeq_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fulldeq_out_valid: got %b expected 1", out_valid); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd3)           begin errors++; $display("FAIL fulldeq_count: got %0d expected 3", count); end
    checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL fulldeq_next_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_pc !== 32'h8000_0004) begin errors++; $display("FAIL fulldeq_out_pc: got %h expected 80000004", out_pc); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fulldeq_refill_count: got %0d expected 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_pc !== 32'h8000_0004 + 32'(4 * i))
        begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, 32'h8000_0004 + 32'(4 * i)); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        in_valid = 1'b1; in_pc = 32'h8000_0000 + 32'(4 * k); in_inst = 32'h3000_0000 + 32'(k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
`ifdef CONFIG_IFQ_BYPASS_EN
      if (k < 10) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, out_valid); end
        checks++; if (out_pc !== 32'h8000_0000 + 32'(4 * k))
          begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, out_pc, 32'h8000_0000 + 32'(4 * k)); end
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 0", k, count); end
`else
      if (k == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_first_valid: got %b expected 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, out_valid); end
        checks++; if (out_pc !== 32'h8000_0000 + 32'(4 * (k - 1)))
          begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, out_pc, 32'h8000_0000 + 32'(4 * (k - 1))); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 1", k, count); end
      end
`endif
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL wrap_end_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush;
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h8000_0200; in_inst = 32'h2000_0000; tick();
    in_pc = 32'h8000_0204; in_inst = 32'h2000_0001; tick();
    flush = 1'b1; in_pc = 32'h8000_0208; in_inst = 32'h2000_0002;
    #1;
    checks++; if (count !== 3'd2)     begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0)           begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL flush_after_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL flush_after_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_pc !== 32'h8000_0200) begin errors++; $display("FAIL flush_storage_kept: got %h expected 80000200", out_pc); end
    in_valid = 1'b1; in_pc = 32'h8000_0300; in_inst = 32'h2000_0003; tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1)           begin errors++; $display("FAIL flush_new_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h8000_0300) begin errors++; $display("FAIL flush_new_pc: got %h expected 80000300", out_pc); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_latency;
    in_valid = 1'b1; in_pc = 32'h8000_0100; in_inst = 32'h0000_0013; out_ready = 1'b1;
    #1;
`ifdef CONFIG_IFQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL bypass_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h8000_0100) begin errors++; $display("FAIL bypass_pc: got %h expected 80000100", out_pc); end
    checks++; if (out_inst !== 32'h0000_0013) begin errors++; $display("FAIL bypass_inst: got %h expected 00000013", out_inst); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL bypass_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_after_valid: got %b expected 0", out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle_valid: got %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1)       begin errors++; $display("FAIL nobypass_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h8000_0100) begin errors++; $display("FAIL nobypass_pc: got %h expected 80000100", out_pc); end
    checks++; if (out_inst !== 32'h0000_0013) begin errors++; $display("FAIL nobypass_inst: got %h expected 00000013", out_inst); end
    checks++; if (count !== 3'd1)           begin errors++; $display("FAIL nobypass_count: got %0d expected 1", count); end
    tick();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL nobypass_drain_count: got %0d expected 0", count); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0400 + 32'(4 * i); in_inst = 32'h4000_0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0)      begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0)    begin errors++; $display("FAIL areset_out_pc: got %h expected 0", out_pc); end
    checks++; if (out_inst !== 32'h0)  begin errors++; $display("FAIL areset_out_inst: got %h expected 0", out_inst); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_wrap();
    test_flush();
    test_latency();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
